// File: rtl/seq_gen.sv
// seq_gen: serial burst generator that shifts a LEN-bit pattern out MSB first,
// repeated rep times with an optional one-cycle idle gap between repetitions.
module seq_gen #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter int             CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             use_def,
    input  logic [LEN-1:0]   pat_in,
    input  logic [CNT_W-1:0] rep,
    input  logic             gap,
    input  logic             abort,
    output logic             Data_out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int             BW   = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [BW-1:0]  LAST = BW'(LEN - 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        DONE
    } state_t;

    state_t           state_q;
    logic [LEN-1:0]   shift_q;
    logic [LEN-1:0]   pat_q;
    logic [BW-1:0]    bit_q;
    logic [CNT_W-1:0] rep_q;
    logic             gap_q;

    logic [LEN-1:0]   pat_d;

    assign pat_d = use_def ? PATTERN : pat_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            pat_q   <= '0;
            bit_q   <= '0;
            rep_q   <= '0;
            gap_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        pat_q   <= pat_d;
                        shift_q <= pat_d;
                        rep_q   <= rep;
                        gap_q   <= gap;
                        bit_q   <= '0;
                        state_q <= (rep != '0) ? SEND : DONE;
                    end
                end
                SEND: begin
                    if (abort) begin
                        state_q <= IDLE;
                        bit_q   <= '0;
                    end else if (bit_q == LAST) begin
                        bit_q <= '0;
                        // rep_q holds repetitions left including this one
                        if (rep_q == ONE) begin
                            rep_q   <= '0;
                            state_q <= DONE;
                        end else begin
                            rep_q <= rep_q - ONE;
                            if (gap_q) begin
                                state_q <= GAP;
                            end else begin
                                shift_q <= pat_q;
                            end
                        end
                    end else begin
                        shift_q <= {shift_q[LEN-2:0], 1'b0};
                        bit_q   <= bit_q + BW'(1);
                    end
                end
                GAP: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else begin
                        shift_q <= pat_q;
                        state_q <= SEND;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign valid    = (state_q == SEND);
    assign Data_out = valid & shift_q[LEN-1];
    assign busy     = (state_q == SEND) || (state_q == GAP);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: directed scoreboard bench for seq_gen; expected per-cycle
// output vectors {valid,Data_out,busy,done} are queued and popped each cycle.
module tb_seq_gen;

    localparam int LEN   = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             use_def = 1'b0;
    logic [LEN-1:0]   pat_in = '0;
    logic [CNT_W-1:0] rep = '0;
    logic             gap = 1'b0;
    logic             abort = 1'b0;
    logic             Data_out;
    logic             valid;
    logic             busy;
    logic             done;

    int cmp = 0;
    int bad = 0;
    int hits = 0;
    logic [3:0] det = '0;
    logic [3:0] q[$];

    always #5 clk = ~clk;

    seq_gen #(
        .LEN(LEN),
        .PATTERN(4'b1011),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .use_def(use_def),
        .pat_in(pat_in),
        .rep(rep),
        .gap(gap),
        .abort(abort),
        .Data_out(Data_out),
        .valid(valid),
        .busy(busy),
        .done(done)
    );

    task automatic push(input logic v, input logic d,
                        input logic b, input logic dn);
        q.push_back({v, d, b, dn});
    endtask

    // Expected burst: bits MSB..LSB per repetition, optional gap, done, idle
    task automatic push_burst(input logic [3:0] p, input int r,
                              input logic g);
        for (int i = 0; i < r; i++) begin
            for (int j = 3; j >= 0; j--) push(1'b1, p[j], 1'b1, 1'b0);
            if (g && i < r - 1) push(1'b0, 1'b0, 1'b1, 1'b0);
        end
        push(1'b0, 1'b0, 1'b0, 1'b1);
        push(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input string tag);
        logic [3:0] obs;
        logic [3:0] exp;
        obs = {valid, Data_out, busy, done};
        exp = (q.size() > 0) ? q.pop_front() : 4'b1111;
        cmp++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs={v,d,b,dn}=%b exp=%b", tag, obs, exp);
        end
        if (valid === 1'b1) begin
            det = {det[2:0], Data_out};
            if (det == 4'b1011) hits++;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    task automatic drain(input string tag);
        int n;
        n = q.size();
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        // async reset with no clock edge
        #2 rst = 1'b1;
        #1;
        push(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_async");

        // start ignored while reset held
        start = 1'b1; use_def = 1'b1; rep = 4'd1;
        push(1'b0, 1'b0, 1'b0, 1'b0);
        step("rst_hold");
        #2 rst = 1'b0;

        // first edge after release accepts start: default pattern, rep=1
        push_burst(4'b1011, 1, 1'b0);
        step("single");
        start = 1'b0;
        drain("single");

        // rep=3 back-to-back, overlapping detector must see 3 hits
        det = '0; hits = 0;
        start = 1'b1; use_def = 1'b1; rep = 4'd3; gap = 1'b0;
        push_burst(4'b1011, 3, 1'b0);
        step("rep3");
        start = 1'b0;
        drain("rep3");
        cmp++;
        assert (hits === 3) else begin
            bad++;
            $error("FAIL det_hits obs=%0d exp=%0d", hits, 3);
        end

        // user pattern with gap
        start = 1'b1; use_def = 1'b0; pat_in = 4'b0110;
        rep = 4'd2; gap = 1'b1;
        push_burst(4'b0110, 2, 1'b1);
        step("gap");
        start = 1'b0; pat_in = 4'b1111; gap = 1'b0;
        drain("gap");

        // rep=0: immediate done
        start = 1'b1; rep = 4'd0;
        push(1'b0, 1'b0, 1'b0, 1'b1);
        push(1'b0, 1'b0, 1'b0, 1'b0);
        step("rep0");
        start = 1'b0;
        drain("rep0");

        // abort during 2nd bit, stray start ignored mid-burst
        start = 1'b1; use_def = 1'b1; rep = 4'd2;
        push(1'b1, 1'b1, 1'b1, 1'b0);
        push(1'b1, 1'b0, 1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b0);
        step("abort_b1");
        use_def = 1'b0; pat_in = 4'b0000; rep = 4'd0;
        step("abort_b2");
        start = 1'b0; abort = 1'b1;
        step("abort_idle");
        abort = 1'b0;
        step("abort_idle2");

        // full burst after abort, with abort held alongside start
        start = 1'b1; abort = 1'b1; use_def = 1'b1; rep = 4'd2;
        push_burst(4'b1011, 2, 1'b0);
        step("post_abort");
        start = 1'b0; abort = 1'b0;
        drain("post_abort");

        // async reset in the middle of a gap
        start = 1'b1; use_def = 1'b1; rep = 4'd2; gap = 1'b1;
        for (int j = 3; j >= 0; j--) push(1'b1, j != 2, 1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b1, 1'b0);
        step("pre_rst");
        start = 1'b0;
        drain("pre_rst");
        #2 rst = 1'b1;
        #1;
        push(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_mid_gap");
        #1 rst = 1'b0;

        // fresh burst on first edge after release
        start = 1'b1; use_def = 1'b0; pat_in = 4'b1100;
        rep = 4'd1; gap = 1'b0;
        push_burst(4'b1100, 1, 1'b0);
        step("fresh");
        start = 1'b0;
        drain("fresh");

        cmp++;
        assert (q.size() == 0) else begin
            bad++;
            $error("FAIL sb_empty obs=%0d exp=%0d", q.size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 SHALL have parameter LEN, default 4; pattern length in bits, 2..16.
REQ-002 SHALL have parameter PATTERN, default 4'b1011; the pattern sent when use_def=1, LEN bits wide.
REQ-003 SHALL have parameter CNT_W, default 4; width of the repetition count.
REQ-004 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  request to begin a burst; sampled only in IDLE.
REQ-007 SHALL have port use_def  input  1  1 selects PATTERN, 0 selects pat_in; captured with start.
REQ-008 SHALL have port pat_in  input  LEN  user pattern, sent MSB first.
REQ-009 SHALL have port rep  input  CNT_W  number of pattern repetitions in the burst.
REQ-010 SHALL have port gap  input  1  1 inserts one idle cycle between repetitions; captured with start.
REQ-011 SHALL have port abort  input  1  synchronous burst cancel.
REQ-012 SHALL have port Data_out  output  1  serial bit; 0 whenever valid=0.
REQ-013 SHALL have port valid  output  1  Data_out carries a pattern bit this cycle.
REQ-014 SHALL have port busy  output  1  a burst is in progress (SEND or GAP).
REQ-015 SHALL have port done  output  1  single-cycle pulse at normal burst completion.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, SEND, GAP and DONE; all outputs are decoded from registered state only.
REQ-017 In IDLE with start=1, SHALL capture the pattern (PATTERN or pat_in), rep and gap into internal registers on the same edge.
REQ-018 On that edge, SHALL go to SEND if rep!=0, or to DONE if rep==0; a rep==0 burst sends no bits.
REQ-019 If start is sampled at edge t, the first bit (pattern MSB) SHALL appear with valid=1 in the cycle after t; bits SHALL follow MSB to LSB, one per cycle.
REQ-020 SHALL use a bit counter of ceil(log2(LEN)) bits and a remaining-repetition counter of CNT_W bits; neither counter shall wrap.
REQ-021 After the LSB of a repetition with repetitions remaining: gap=0 SHALL reload the pattern and send the next MSB in the following cycle (back-to-back); gap=1 SHALL enter GAP for exactly one cycle, then return to SEND.
REQ-022 In GAP: Data_out=0, valid=0, busy=1.
REQ-023 After the LSB of the final repetition, SHALL enter DONE: done=1, busy=0, valid=0 for one cycle, then IDLE.
REQ-024 SHALL assert busy=1 in SEND and GAP only; done=1 in DONE only.
REQ-025 SHALL ignore start outside IDLE; inputs captured for the current burst shall not change mid-burst.
REQ-026 abort=1 in SEND or GAP SHALL force IDLE on the next edge with no done pulse; abort has priority over every other transition; abort in IDLE or DONE has no effect.
REQ-027 In IDLE, start and abort asserted together SHALL start a burst (abort is ignored in IDLE).
REQ-028 Total burst length from start to done SHALL be rep*LEN + (gap ? rep-1 : 0) + 1 cycles.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, clear all counters and the shift register, and drive Data_out=0, valid=0, busy=0, done=0, including mid-burst.
REQ-030 After rst deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-031 use_def=1, rep=1, gap=0, start at edge t -> Data_out/valid = 1,0,1,1 with valid=1 in cycles t+1..t+4; done=1 in t+5; busy=1 in t+1..t+4.
REQ-032 use_def=1, rep=3, gap=0 -> contiguous stream 101110111011 with valid=1 for 12 cycles, then one done pulse; a 1011 overlapping Moore detector on the stream reports exactly 3 hits.
REQ-033 use_def=0, pat_in=4'b0110, rep=2, gap=1 -> stream 0110, idle (valid=0, Data_out=0), 0110; done one cycle after the last bit.
REQ-034 rep=0, start -> done=1 in the next cycle; valid=0 and busy=0 throughout.
REQ-035 rep=2, abort during the 2nd bit -> IDLE on the next edge, no done pulse; start pulses during the burst are ignored, and a new start afterwards sends a full burst.
REQ-036 rst asserted asynchronously mid-GAP -> all outputs 0 immediately; first edge after release with start=1 begins a fresh burst.
